// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave at bus address 7'h20.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RACK      = 4'd8
  } i2c_state_t;

  localparam logic [6:0]  SLAVE_ADDR = 7'h20;
  localparam int unsigned NUM_REGS   = 32;

endpackage

// File: rtl/i2c_bus_timeout.sv
// SCL inactivity counter: saturates one short of TIMEOUT_CYCLES and flags expiry,
// so the owning FSM leaves its state exactly TIMEOUT_CYCLES cycles after the last edge.
module i2c_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + TO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Control FSM for the I2C slave: address, pointer, write and read phases with repeated START.
// Optional SCL inactivity abort is built when I2C_BUS_TIMEOUT_EN is defined.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic SCL_posedge,
  input  logic SCL_negedge,
  input  logic bit_done,
  input  logic addr_valid,
  input  logic rw_bit,
  input  logic ack_in,
  output logic clear_start,
  output logic clear_stop,
  output logic count_clear,
  output logic shift_en,
  output logic sel_load,
  output logic sel_inc,
  output logic mem_we,
  output logic send_ack,
  output logic out_en,
  output logic busy
);

  if ((TIMEOUT_CYCLES == 0) || (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W))) begin : g_bad_cfg
    $error("i2c_slave_ctrl: TIMEOUT_CYCLES must be nonzero and below 2**TO_W");
  end

  i2c_state_t state_q;
  i2c_state_t state_d;
  logic       byte_end;
  logic       to_expired;

  assign byte_end = SCL_negedge & bit_done;

`ifdef I2C_BUS_TIMEOUT_EN
  logic to_clear;
  // start/stop also restart the window so a fresh transaction is never aborted at once
  assign to_clear = (state_q == IDLE) | SCL_posedge | SCL_negedge | start | stop;

  i2c_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_bus_timeout (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (to_clear),
    .expired_o(to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else if (to_expired) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        ADDR:      if (byte_end) state_d = addr_valid ? ADDR_ACK : IDLE;
                   else          state_d = ADDR;
        ADDR_ACK:  if (SCL_negedge) state_d = rw_bit ? RDATA : PTR;
                   else             state_d = ADDR_ACK;
        PTR:       state_d = byte_end ? PTR_ACK : PTR;
        PTR_ACK:   state_d = SCL_negedge ? WDATA : PTR_ACK;
        WDATA:     state_d = byte_end ? WDATA_ACK : WDATA;
        WDATA_ACK: state_d = SCL_negedge ? WDATA : WDATA_ACK;
        RDATA:     state_d = byte_end ? RACK : RDATA;
        RACK:      if (SCL_negedge) state_d = ack_in ? RDATA : IDLE;
                   else             state_d = RACK;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Levels decode the state register; pulses mark only the qualifying cycle.
  always_comb begin
    clear_start = 1'b0;
    clear_stop  = 1'b0;
    count_clear = 1'b0;
    shift_en    = 1'b0;
    sel_load    = 1'b0;
    sel_inc     = 1'b0;
    mem_we      = 1'b0;
    send_ack    = 1'b0;
    out_en      = 1'b0;
    busy        = 1'b0;
    if (reset) begin
      clear_start = 1'b1;
      clear_stop  = 1'b1;
    end else begin
      shift_en = (state_q == ADDR) | (state_q == PTR) | (state_q == WDATA);
      send_ack = (state_q == ADDR_ACK) | (state_q == PTR_ACK) | (state_q == WDATA_ACK);
      out_en   = (state_q == RDATA) & ~byte_end;
      busy     = (state_q != IDLE);
      if (stop) begin
        clear_stop = 1'b1;
      end else if (start) begin
        clear_start = 1'b1;
        count_clear = 1'b1;
      end else if (to_expired) begin
        clear_start = 1'b1;
        clear_stop  = 1'b1;
        send_ack    = 1'b0;
        out_en      = 1'b0;
      end else begin
        case (state_q)
          ADDR_ACK:  count_clear = SCL_negedge;
          PTR:       sel_load    = byte_end;
          PTR_ACK:   count_clear = SCL_negedge;
          WDATA:     mem_we      = byte_end;
          WDATA_ACK: begin
            sel_inc     = SCL_negedge;
            count_clear = SCL_negedge;
          end
          RACK: begin
            sel_inc     = SCL_negedge & ack_in;
            count_clear = SCL_negedge & ack_in;
          end
          default: begin
            count_clear = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: the bench plays bus master and slave datapath,
// and checks against a transaction-level register-file model.
module tb_i2c_slave_ctrl;

  localparam int         TO_CYC = 50;
  localparam logic [6:0] ADDR7  = 7'h20;

  logic clock, reset, start, stop, SCL_posedge, SCL_negedge;
  logic bit_done, addr_valid, rw_bit, ack_in;
  logic clear_start, clear_stop, count_clear, shift_en, sel_load, sel_inc;
  logic mem_we, send_ack, out_en, busy;

  i2c_slave_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(17)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .SCL_posedge(SCL_posedge), .SCL_negedge(SCL_negedge), .bit_done(bit_done),
    .addr_valid(addr_valid), .rw_bit(rw_bit), .ack_in(ack_in),
    .clear_start(clear_start), .clear_stop(clear_stop), .count_clear(count_clear),
    .shift_en(shift_en), .sel_load(sel_load), .sel_inc(sel_inc), .mem_we(mem_we),
    .send_ack(send_ack), .out_en(out_en), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total, bad;

  // datapath emulation driven by the DUT controls, and the expected register file
  logic [7:0] dp_regs  [32];
  logic [7:0] exp_regs [32];
  logic [7:0] shreg, rd_shift;
  logic [4:0] ptr;
  logic       sda_m;
  int         bitcnt;
  int         n_we, n_load;
  logic s_cs, s_cst, s_cc, s_se, s_sl, s_si, s_we, s_ack, s_oe, s_busy;

  assign bit_done   = (bitcnt == 8);
  assign addr_valid = (shreg[7:1] == ADDR7);
  assign rw_bit     = shreg[0];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // One clock: sample outputs mid-cycle, apply datapath effects just after the edge.
  task automatic step();
    #1;
    s_cs = clear_start; s_cst = clear_stop; s_cc = count_clear; s_se = shift_en;
    s_sl = sel_load; s_si = sel_inc; s_we = mem_we; s_ack = send_ack;
    s_oe = out_en; s_busy = busy;
    @(posedge clock);
    #1;
    if (s_cs)  start = 1'b0;
    if (s_cst) stop  = 1'b0;
    if (s_we) begin dp_regs[ptr] = shreg; n_we++; end
    if (s_sl) begin ptr = shreg[4:0]; n_load++; end
    else if (s_si) ptr = ptr + 5'd1;
    if (s_cc) bitcnt = 0;
    else if ((s_se || s_oe) && SCL_posedge && bitcnt < 8) begin
      if (s_se) shreg = {shreg[6:0], sda_m};
      if (s_oe) rd_shift = {rd_shift[6:0], dp_regs[ptr][3'(7 - bitcnt)]};
      bitcnt++;
    end
    @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    SCL_posedge = 1'b1; step();
    SCL_posedge = 1'b0; step();
    SCL_negedge = 1'b1; step();
    SCL_negedge = 1'b0; step();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    SCL_posedge = 1'b1; step(); acked = s_ack;
    SCL_posedge = 1'b0; step();
    SCL_negedge = 1'b1; step();
    SCL_negedge = 1'b0; step();
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] data, output logic drive_ok);
    drive_ok = 1'b1;
    rd_shift = 8'h00;
    sda_m    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      SCL_posedge = 1'b1; step(); if (s_oe !== 1'b1) drive_ok = 1'b0;
      SCL_posedge = 1'b0; step();
      SCL_negedge = 1'b1; step(); if (s_oe !== 1'(i < 7)) drive_ok = 1'b0;
      SCL_negedge = 1'b0; step();
    end
    ack_in = ack;
    SCL_posedge = 1'b1; step(); if (s_oe !== 1'b0 || s_ack !== 1'b0) drive_ok = 1'b0;
    SCL_posedge = 1'b0; step();
    SCL_negedge = 1'b1; step();
    SCL_negedge = 1'b0; ack_in = 1'b0; step();
    data = rd_shift;
  endtask

  task automatic bus_start(output logic ok);
    start = 1'b1; step(); ok = s_cs & s_cc;
  endtask

  task automatic bus_stop(output logic ok);
    stop = 1'b1; step(); ok = s_cst;
  endtask

  task automatic write_txn(input logic [4:0] p, input int n, input logic [7:0] first);
    logic ok, a, ok_stop;
    int acks, diffs;
    logic [7:0] d;
    logic [4:0] idx;
    n_we = 0; n_load = 0; acks = 0;
    bus_start(ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_start: clear pulses=%b want 1", ok); end
    write_byte({ADDR7, 1'b0}, a); acks += int'(a);
    write_byte({3'($urandom), p}, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? first : 8'($urandom);
      write_byte(d, a); acks += int'(a);
      idx = p + 5'(i);
      exp_regs[idx] = d;
    end
    bus_stop(ok_stop);
    step();
    total++; if (!ok_stop) begin bad++; $display("FAIL wr_clear_stop: got %b want 1", ok_stop); end
    total++; if (acks != n + 2) begin bad++; $display("FAIL wr_acks: got %0d want %0d", acks, n + 2); end
    total++; if (n_load != 1) begin bad++; $display("FAIL wr_sel_load: got %0d want 1", n_load); end
    total++; if (n_we != n) begin bad++; $display("FAIL wr_mem_we: got %0d want %0d", n_we, n); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL wr_idle: busy=%b want 0", s_busy); end
    diffs = 0;
    for (int i = 0; i < 32; i++) if (dp_regs[i] !== exp_regs[i]) diffs++;
    total++; if (diffs != 0) begin bad++; $display("FAIL wr_regfile: %0d entries differ want 0", diffs); end
  endtask

  task automatic read_txn(input logic [4:0] p, input int n);
    logic ok, a, dok;
    int acks;
    logic [7:0] d;
    logic [4:0] idx;
    n_we = 0; acks = 0;
    bus_start(ok);
    write_byte({ADDR7, 1'b0}, a); acks += int'(a);
    write_byte({3'($urandom), p}, a); acks += int'(a);
    bus_start(ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_rep_start: clear pulses=%b want 1", ok); end
    write_byte({ADDR7, 1'b1}, a); acks += int'(a);
    total++; if (acks != 3) begin bad++; $display("FAIL rd_acks: got %0d want 3", acks); end
    for (int i = 0; i < n; i++) begin
      read_byte(1'(i < n - 1), d, dok);
      idx = p + 5'(i);
      total++; if (d !== exp_regs[idx]) begin
        bad++; $display("FAIL rd_data[%0d]: got %h want %h (reg %0d)", i, d, exp_regs[idx], idx);
      end
      total++; if (!dok) begin bad++; $display("FAIL rd_sda_drive[%0d]: got %b want 1", i, dok); end
    end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rd_idle_after_nack: busy=%b want 0", s_busy); end
    total++; if (n_we != 0) begin bad++; $display("FAIL rd_no_we: got %0d want 0", n_we); end
    bus_stop(ok);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'($urandom); stop = 1'($urandom);
    SCL_posedge = 1'($urandom); SCL_negedge = 1'($urandom); ack_in = 1'($urandom);
    step();
    total++; if ({s_cs, s_cst} !== 2'b11) begin bad++; $display("FAIL reset_clear: got %b want 11", {s_cs, s_cst}); end
    total++; if ({s_cc, s_se, s_sl, s_si, s_we, s_ack, s_oe, s_busy} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs: got %b want 00000000", {s_cc, s_se, s_sl, s_si, s_we, s_ack, s_oe, s_busy});
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    SCL_posedge = 1'b0; SCL_negedge = 1'b0; ack_in = 1'b0;
    step();
    total++; if ({s_cs, s_cst, s_cc, s_busy} !== 4'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 0000", {s_cs, s_cst, s_cc, s_busy});
    end
  endtask

  task automatic test_write();
    write_txn(5'd5, 1, 8'hA5);
    write_txn(5'($urandom), 1, 8'($urandom));
  endtask

  task automatic test_addr_mismatch(input logic [6:0] a7);
    logic ok, a;
    n_we = 0; n_load = 0;
    bus_start(ok);
    write_byte({a7, 1'($urandom)}, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL mis_ack: addr %h send_ack=%b want 0", a7, a); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL mis_idle: busy=%b want 0", s_busy); end
    write_byte(8'($urandom), a);
    total++; if (n_we != 0 || n_load != 0) begin
      bad++; $display("FAIL mis_pulses: we=%0d load=%0d want 0 0", n_we, n_load);
    end
    bus_stop(ok);
  endtask

  task automatic test_burst_wrap();
    write_txn(5'd30, 3, 8'($urandom));
    read_txn(5'd31, 2);
  endtask

  task automatic test_stop_mid_byte();
    logic ok, a;
    logic [4:0] p;
    int diffs;
    p = 5'($urandom);
    n_we = 0;
    bus_start(ok);
    write_byte({ADDR7, 1'b0}, a);
    write_byte({3'b000, p}, a);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_clear_stop: got %b want 1", ok); end
    step();
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL mid_idle: busy=%b want 0", s_busy); end
    total++; if (n_we != 0) begin bad++; $display("FAIL mid_no_we: got %0d want 0", n_we); end
    diffs = 0;
    for (int i = 0; i < 32; i++) if (dp_regs[i] !== exp_regs[i]) diffs++;
    total++; if (diffs != 0) begin bad++; $display("FAIL mid_regfile: %0d entries differ want 0", diffs); end
  endtask

  task automatic test_reset_in_rdata();
    logic ok, a;
    bus_start(ok);
    write_byte({ADDR7, 1'b1}, a);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    total++; if (s_oe !== 1'b1) begin bad++; $display("FAIL rrd_out_en: got %b want 1", s_oe); end
    reset = 1'b1;
    step();
    total++; if ({s_cs, s_cst, s_oe, s_ack} !== 4'b1100) begin
      bad++; $display("FAIL rrd_in_reset: got %b want 1100", {s_cs, s_cst, s_oe, s_ack});
    end
    reset = 1'b0;
    step();
    total++; if ({s_oe, s_busy} !== 2'b00) begin bad++; $display("FAIL rrd_after: oe,busy=%b want 00", {s_oe, s_busy}); end
    total++; if ({s_cs, s_cst, s_cc, s_sl, s_si, s_we} !== 6'b0) begin
      bad++; $display("FAIL rrd_pulses: got %b want 000000", {s_cs, s_cst, s_cc, s_sl, s_si, s_we});
    end
  endtask

  task automatic test_timeout();
    logic ok, a;
    bus_start(ok);
    write_byte({ADDR7, 1'b0}, a);
    write_byte({3'b000, 5'($urandom)}, a);
    // the ack slot's trailing cycle is already the first cycle after the last SCL edge
`ifdef I2C_BUS_TIMEOUT_EN
    begin
      int fire, idle_at, pulses;
      fire = -1; idle_at = -1; pulses = 0;
      for (int k = 1; k <= TO_CYC + 5; k++) begin
        step();
        if (s_cst && s_cs) begin pulses++; if (fire < 0) fire = k; end
        if (idle_at < 0 && s_busy === 1'b0) idle_at = k;
      end
      total++; if (fire != TO_CYC - 1) begin bad++; $display("FAIL to_fire: step %0d want %0d", fire, TO_CYC - 1); end
      total++; if (idle_at != TO_CYC) begin bad++; $display("FAIL to_idle: step %0d want %0d", idle_at, TO_CYC); end
      total++; if (pulses != 1) begin bad++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    end
`else
    for (int k = 0; k < 3 * TO_CYC; k++) step();
    total++; if ({s_busy, s_se} !== 2'b11) begin bad++; $display("FAIL to_hold: busy,shift=%b want 11", {s_busy, s_se}); end
`endif
    bus_stop(ok);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) write_txn(5'($urandom), int'($urandom_range(1, 4)), 8'($urandom));
      else            read_txn(5'($urandom), int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; ack_in = 1'b0;
    SCL_posedge = 1'b0; SCL_negedge = 1'b0;
    shreg = 8'h00; rd_shift = 8'h00; ptr = 5'd0; sda_m = 1'b0; bitcnt = 0;
    n_we = 0; n_load = 0;
    for (int i = 0; i < 32; i++) begin
      dp_regs[i]  = 8'($urandom);
      exp_regs[i] = dp_regs[i];
    end
    @(negedge clock);
    test_reset();
    test_write();
    test_addr_mismatch(7'h21);
    test_addr_mismatch(7'h20 ^ 7'($urandom_range(1, 127)));
    test_burst_wrap();
    test_stop_mid_byte();
    test_reset_in_rdata();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
